// File: rtl/ndp_bram_loader_pkg.sv
// Shared definitions for the NDP dual-width BRAM fill path: default widths
// so the loader and the BRAM agree, plus the loader FSM state encoding.
package ndp_bram_loader_pkg;

    localparam int NDP_A_WIDTH         = 32;
    localparam int NDP_A_ADDRESS_WIDTH = 2;
    localparam int NDP_DEPTH           = 4;
    localparam int NDP_B_RATIO         = 2;
    localparam int NDP_B_ADDRESS_WIDTH = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/ndp_bram_loader.sv
// Upstream fill stage of the NDP dual-width BRAM. Writes a stream of A words
// to port-A addresses 0.. and announces each committed B word so the port-B
// side can start reading early. All outputs are registered.
module ndp_bram_loader
    import ndp_bram_loader_pkg::*;
#(
    parameter int A_WIDTH         = NDP_A_WIDTH,
    parameter int A_ADDRESS_WIDTH = NDP_A_ADDRESS_WIDTH,
    parameter int DEPTH           = NDP_DEPTH,
    parameter int B_RATIO         = NDP_B_RATIO,
    parameter int B_ADDRESS_WIDTH = NDP_B_ADDRESS_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [A_ADDRESS_WIDTH:0]   num_words,
    input  logic                       s_valid,
    input  logic [A_WIDTH-1:0]         s_data,
    output logic                       s_ready,
    output logic                       ena,
    output logic                       wea,
    output logic [A_ADDRESS_WIDTH-1:0] addra,
    output logic [A_WIDTH-1:0]         dina,
    output logic                       bword_valid,
    output logic [B_ADDRESS_WIDTH-1:0] bword_addr,
    output logic                       bword_partial,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);

    localparam int                         B_SHIFT     = (B_RATIO > 1) ? $clog2(B_RATIO) : 0;
    localparam logic [A_ADDRESS_WIDTH-1:0] B_LANE_MASK = A_ADDRESS_WIDTH'(B_RATIO - 1);
    localparam logic [A_ADDRESS_WIDTH:0]   DEPTH_C     = (A_ADDRESS_WIDTH + 1)'(DEPTH);
    localparam logic [A_ADDRESS_WIDTH:0]   CNT_ONE     = (A_ADDRESS_WIDTH + 1)'(1);

    if (DEPTH > (1 << A_ADDRESS_WIDTH) || !is_pow2(B_RATIO)) begin : g_param_check
        $error("ndp_bram_loader: DEPTH must fit the port-A address space and B_RATIO must be a power of two");
    end

    state_e                       state_q, state_d;
    logic [A_ADDRESS_WIDTH:0]     cnt_q, cnt_d;
    logic [A_ADDRESS_WIDTH:0]     nw_q, nw_d;
    logic                         last_wr_q, last_wr_d;
    logic                         s_ready_q, s_ready_d;
    logic                         wea_q, wea_d;
    logic [A_ADDRESS_WIDTH-1:0]   addra_q, addra_d;
    logic [A_WIDTH-1:0]           dina_q, dina_d;
    logic                         bword_valid_q, bword_valid_d;
    logic [B_ADDRESS_WIDTH-1:0]   bword_addr_q, bword_addr_d;
    logic                         bword_partial_q, bword_partial_d;
    logic                         busy_q, busy_d;
    logic                         done_q, done_d;
    logic                         err_q, err_d;

    logic                         accept;
    logic [A_ADDRESS_WIDTH:0]     cnt_inc;
    logic                         lane_full;

    assign accept    = s_valid && s_ready_q;
    assign cnt_inc   = cnt_q + CNT_ONE;
    // The word written last cycle closes a B word when it lands in the top lane.
    assign lane_full = (addra_q & B_LANE_MASK) == B_LANE_MASK;

    // State and registered outputs; reset abandons any load in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            nw_q            <= '0;
            last_wr_q       <= 1'b0;
            s_ready_q       <= 1'b0;
            wea_q           <= 1'b0;
            addra_q         <= '0;
            dina_q          <= '0;
            bword_valid_q   <= 1'b0;
            bword_addr_q    <= '0;
            bword_partial_q <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            err_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            nw_q            <= nw_d;
            last_wr_q       <= last_wr_d;
            s_ready_q       <= s_ready_d;
            wea_q           <= wea_d;
            addra_q         <= addra_d;
            dina_q          <= dina_d;
            bword_valid_q   <= bword_valid_d;
            bword_addr_q    <= bword_addr_d;
            bword_partial_q <= bword_partial_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            err_q           <= err_d;
        end
    end

    // Next state, write issue and next values of every registered output.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        nw_d      = nw_q;
        last_wr_d = 1'b0;
        wea_d     = 1'b0;
        addra_d   = addra_q;
        dina_d    = dina_q;
        err_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (num_words != '0 && num_words <= DEPTH_C) begin
                        state_d = ST_LOAD;
                        cnt_d   = '0;
                        nw_d    = num_words;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    wea_d     = 1'b1;
                    addra_d   = cnt_q[A_ADDRESS_WIDTH-1:0];
                    dina_d    = s_data;
                    cnt_d     = cnt_inc;
                    last_wr_d = (cnt_inc == nw_q);
                    if (cnt_inc == nw_q) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // Registered so s_ready drops the cycle right after the final accept.
        s_ready_d = (state_d == ST_LOAD);
        busy_d    = (state_d != ST_IDLE);
        done_d    = (state_d == ST_DONE);

        // Notify one cycle after the write that completes (or ends) a B word.
        bword_valid_d   = wea_q && (lane_full || last_wr_q);
        bword_partial_d = wea_q && last_wr_q && !lane_full;
        bword_addr_d    = bword_valid_d ? B_ADDRESS_WIDTH'(addra_q >> B_SHIFT) : bword_addr_q;
    end

    assign s_ready       = s_ready_q;
    assign ena           = wea_q;
    assign wea           = wea_q;
    assign addra         = addra_q;
    assign dina          = dina_q;
    assign bword_valid   = bword_valid_q;
    assign bword_addr    = bword_addr_q;
    assign bword_partial = bword_partial_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;

endmodule

// File: tb/tb_ndp_bram_loader.sv
// Bench for ndp_bram_loader: drives loads into a behavioural dual-width BRAM,
// with a scoreboard of expected writes, B-word notifications, done and err.
module tb_ndp_bram_loader;

    localparam int AW  = 32;
    localparam int AAW = 2;
    localparam int DEP = 4;
    localparam int R   = 2;
    localparam int BAW = 1;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [AAW:0]   num_words;
    logic           s_valid;
    logic [AW-1:0]  s_data;
    logic           s_ready, ena, wea;
    logic [AAW-1:0] addra;
    logic [AW-1:0]  dina;
    logic           bword_valid;
    logic [BAW-1:0] bword_addr;
    logic           bword_partial, busy, done, err;

    always #5 clk = ~clk;

    ndp_bram_loader #(
        .A_WIDTH(AW), .A_ADDRESS_WIDTH(AAW), .DEPTH(DEP), .B_RATIO(R), .B_ADDRESS_WIDTH(BAW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .num_words(num_words),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .ena(ena), .wea(wea), .addra(addra), .dina(dina),
        .bword_valid(bword_valid), .bword_addr(bword_addr), .bword_partial(bword_partial),
        .busy(busy), .done(done), .err(err)
    );

    // Behavioural BRAM: port A writes, port B read as R concatenated A words.
    logic [AW-1:0] mem [0:DEP-1];
    always @(posedge clk) begin
        if (ena && wea) mem[addra] <= dina;
    end

    typedef struct packed { logic [AAW-1:0] addr; logic [AW-1:0] data; } wr_t;
    typedef struct packed { logic [BAW-1:0] addr; logic partial; logic last; } bw_t;

    wr_t exp_wr[$];
    bw_t exp_bw[$];
    int  exp_done = 0;
    int  exp_err  = 0;
    int  n_checks = 0;
    int  n_pass   = 0;
    wr_t mw;
    bw_t mb;
    bit  bp_pat [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: whenever the DUT presents a write/notification/pulse, pop and compare.
    always @(negedge clk) begin
        if (ena || wea) chk("ena equals wea", 64'(ena), 64'(wea));
        if (wea) begin
            chk("write expected", 64'(exp_wr.size() > 0), 64'd1);
            if (exp_wr.size() > 0) begin
                mw = exp_wr.pop_front();
                chk("write addra", 64'(addra), 64'(mw.addr));
                chk("write dina", 64'(dina), 64'(mw.data));
            end
        end
        if (bword_valid) begin
            chk("bword expected", 64'(exp_bw.size() > 0), 64'd1);
            if (exp_bw.size() > 0) begin
                mb = exp_bw.pop_front();
                chk("bword_addr", 64'(bword_addr), 64'(mb.addr));
                chk("bword_partial", 64'(bword_partial), 64'(mb.partial));
                chk("final bword with done", 64'(done), 64'(mb.last));
            end
        end
        if (done) begin
            chk("done expected", 64'(exp_done > 0), 64'd1);
            if (exp_done > 0) exp_done--;
        end
        if (err) begin
            chk("err expected", 64'(exp_err > 0), 64'd1);
            if (exp_err > 0) exp_err--;
        end
    end

    // Reference model: n words land at 0..n-1; one notification per B word,
    // the last one partial when n is not a multiple of R, plus one done.
    task automatic expect_load(input int n, input logic [AW-1:0] d [DEP]);
        int nb;
        nb = (n + R - 1) / R;
        for (int i = 0; i < n; i++) exp_wr.push_back('{addr: AAW'(i), data: d[i]});
        for (int b = 0; b < nb; b++)
            exp_bw.push_back('{addr: BAW'(b), partial: (b == nb - 1) && (n % R != 0), last: (b == nb - 1)});
        exp_done++;
    endtask

    // Drives one load. Called and returns at a negedge with the DUT idle.
    // mode: 0 valid always, 1 fixed backpressure pattern, 2 random valid.
    task automatic run_load(input int n, input int mode, input int abort_after, input bit dup_start);
        logic [AW-1:0] d [DEP];
        logic v, rdy;
        int idx, k, w, nb;
        for (int i = 0; i < DEP; i++) d[i] = (mode == 0) ? AW'(32'hA0 + i) : $urandom;
        expect_load(n, d);
        start = 1'b1; num_words = (AAW+1)'(n);
        @(negedge clk);
        start = 1'b0;
        idx = 0; k = 0;
        while (idx < n && k < 200) begin
            v = (mode == 0) ? 1'b1 : (mode == 1) ? bp_pat[k % 6] : 1'($urandom_range(0, 1));
            s_valid = v;
            s_data  = v ? d[idx] : $urandom;
            rdy = s_ready;
            if (dup_start && k == 1) begin start = 1'b1; num_words = 3'd1; end
            @(negedge clk);
            start = 1'b0;
            if (rdy) chk("wea follows accept", 64'(wea), 64'(v));
            if (v && rdy) idx++;
            k++;
            if (abort_after > 0 && idx == abort_after) break;
        end
        s_valid = 1'b0;
        chk("accepts within budget", 64'(idx), 64'(abort_after > 0 ? abort_after : n));
        if (abort_after > 0) begin
            rst = 1'b1;
            @(negedge clk);
            chk("reset busy", 64'(busy), 64'd0);
            chk("reset wea", 64'(wea), 64'd0);
            chk("reset done", 64'(done), 64'd0);
            chk("reset bword_valid", 64'(bword_valid), 64'd0);
            chk("reset s_ready", 64'(s_ready), 64'd0);
            rst = 1'b0;
            exp_wr.delete(); exp_bw.delete(); exp_done = 0;
            return;
        end
        w = 0;
        while (!done && w < 20) begin @(negedge clk); w++; end
        chk("done within bound", 64'(done), 64'd1);
        @(negedge clk);
        chk("idle after done busy", 64'(busy), 64'd0);
        chk("idle after done s_ready", 64'(s_ready), 64'd0);
        chk("done count", 64'(exp_done), 64'd0);
        chk("writes drained", 64'(exp_wr.size()), 64'd0);
        chk("bwords drained", 64'(exp_bw.size()), 64'd0);
        nb = n / R;
        for (int b = 0; b < nb; b++)
            chk("port B word", {mem[R*b+1], mem[R*b]}, {d[R*b+1], d[R*b]});
        if (n % R != 0) chk("port B low lane", 64'(mem[R*nb]), 64'(d[R*nb]));
    endtask

    task automatic bad_start(input int n);
        start = 1'b1; num_words = (AAW+1)'(n);
        exp_err++;
        @(negedge clk);
        start = 1'b0;
        chk("bad start busy", 64'(busy), 64'd0);
        chk("bad start s_ready", 64'(s_ready), 64'd0);
        chk("bad start err", 64'(err), 64'd1);
        @(negedge clk);
        chk("bad start still idle", 64'(busy), 64'd0);
        chk("err pulse count", 64'(exp_err), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; start = 1'b0; num_words = '0; s_valid = 1'b0; s_data = '0;
        for (int i = 0; i < DEP; i++) mem[i] = '0;
        repeat (3) @(negedge clk);
        chk("reset outputs",
            64'({s_ready, ena, wea, addra, bword_valid, bword_addr, bword_partial, busy, done, err}), 64'd0);
        chk("reset dina", 64'(dina), 64'd0);
        rst = 1'b0;

        run_load(4, 0, 0, 1'b0);
        chk("portB addr0 literal", {mem[1], mem[0]}, 64'h000000A1_000000A0);
        chk("portB addr1 literal", {mem[3], mem[2]}, 64'h000000A3_000000A2);
        run_load(4, 1, 0, 1'b0);
        run_load(3, 0, 0, 1'b0);
        bad_start(0);
        bad_start(5);
        run_load(4, 0, 2, 1'b0);
        run_load(4, 0, 0, 1'b0);
        run_load(4, 0, 0, 1'b1);

        for (int t = 0; t < 30; t++) begin
            if ($urandom_range(0, 5) == 0) bad_start($urandom_range(0, 1) == 0 ? 0 : $urandom_range(5, 7));
            run_load($urandom_range(1, 4), 2, 0, 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
